// File: rtl/rx_pkg.sv
// Shared types and constants for the USB receive-side packet control unit.
package rx_pkg;

  // Packet class, decoded from pid[1:0].
  typedef enum logic [1:0] {
    NONE      = 2'b00,
    TOKEN     = 2'b01,
    HANDSHAKE = 2'b10,
    DATA      = 2'b11
  } rx_type_t;

  typedef enum logic [3:0] {
    StIdle,
    StWaitSync,
    StWaitPid,
    StTokenBytes,
    StWaitHsEop,
    StFlush,
    StDataWait,
    StStore,
    StDone,
    StErrWait,
    StEidle
  } rx_state_t;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;

  localparam logic [7:0] SyncByteDefault = 8'h80;

endpackage

// File: rtl/rx_pid_check.sv
// Combinational PID byte check: upper nibble is the PID, lower nibble its complement.
module rx_pid_check
  import rx_pkg::*;
(
  input  logic [7:0] pid_byte_i,
  output logic [3:0] pid_o,
  output rx_type_t   type_o,
  output logic       valid_o
);

  // Class 00 is reserved, so a correctly complemented PID of that class is still rejected.
  always_comb begin
    pid_o   = pid_byte_i[7:4];
    type_o  = rx_type_t'(pid_byte_i[5:4]);
    valid_o = (pid_byte_i[3:0] == ~pid_byte_i[7:4]) && (pid_byte_i[5:4] != 2'b00);
  end

endmodule

// File: rtl/rx_packet_cu.sv
// Receive packet control unit: validates SYNC/PID, classifies the packet,
// strobes data-buffer writes and reports completion or error.
module rx_packet_cu
  import rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SyncByteDefault,
  parameter int unsigned MAX_DATA_BYTES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_edge,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       eop,
  output logic       rcving,
  output logic       r_error,
  output logic       w_enable,
  output logic       buffer_flush,
  output logic       packet_done,
  output logic [3:0] rx_pid,
  output rx_type_t   rx_type,
  output logic [6:0] byte_count
);

  // Payload limit including the two CRC16 bytes.
  localparam logic [6:0] ByteLimit = 7'(MAX_DATA_BYTES + 2);

  rx_state_t  state_q;
  logic [1:0] tok_cnt_q;
  logic [3:0] rx_pid_q;
  rx_type_t   rx_type_q;
  logic [6:0] byte_count_q;

  logic [3:0] pid_dec;
  rx_type_t   type_dec;
  logic       pid_valid;

  rx_pid_check u_pid_check (
    .pid_byte_i (rcv_data),
    .pid_o      (pid_dec),
    .type_o     (type_dec),
    .valid_o    (pid_valid)
  );

  // Packet sequencing; eop is tested before byte_received so a coincident byte is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tok_cnt_q    <= 2'd0;
      rx_pid_q     <= 4'd0;
      rx_type_q    <= NONE;
      byte_count_q <= 7'd0;
    end else begin
      unique case (state_q)
        StIdle: if (d_edge) state_q <= StWaitSync;
        StWaitSync: begin
          if (eop) begin
            state_q <= StEidle;
          end else if (byte_received) begin
            state_q <= (rcv_data == SYNC_BYTE) ? StWaitPid : StErrWait;
          end
        end
        StWaitPid: begin
          if (eop) begin
            state_q <= StEidle;
          end else if (byte_received) begin
            if (!pid_valid) begin
              state_q <= StErrWait;
            end else begin
              rx_pid_q  <= pid_dec;
              rx_type_q <= type_dec;
              unique case (type_dec)
                TOKEN: begin
                  state_q   <= StTokenBytes;
                  tok_cnt_q <= 2'd0;
                end
                HANDSHAKE: state_q <= StWaitHsEop;
                default:   state_q <= StFlush;
              endcase
            end
          end
        end
        StTokenBytes: begin
          if (eop) begin
            state_q <= (tok_cnt_q == 2'd2) ? StDone : StEidle;
          end else if (byte_received) begin
            if (tok_cnt_q == 2'd2) state_q <= StErrWait;
            else                   tok_cnt_q <= tok_cnt_q + 2'd1;
          end
        end
        StWaitHsEop: begin
          if (eop)                state_q <= StDone;
          else if (byte_received) state_q <= StErrWait;
        end
        StFlush: begin
          byte_count_q <= 7'd0;
          state_q      <= StDataWait;
        end
        StDataWait: begin
          if (eop) begin
            state_q <= (byte_count_q >= 7'd2 && byte_count_q <= ByteLimit) ? StDone : StEidle;
          end else if (byte_received) begin
            state_q <= (byte_count_q < ByteLimit) ? StStore : StErrWait;
          end
        end
        StStore: begin
          if (byte_count_q != 7'h7f) byte_count_q <= byte_count_q + 7'd1;
          state_q <= StDataWait;
        end
        StDone:    state_q <= StIdle;
        StErrWait: if (eop) state_q <= StEidle;
        StEidle:   if (d_edge) state_q <= StWaitSync;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Moore decode of the status and strobe outputs.
  always_comb begin
    rcving       = !(state_q inside {StIdle, StDone, StEidle});
    r_error      = (state_q == StErrWait) || (state_q == StEidle);
    w_enable     = (state_q == StStore);
    buffer_flush = (state_q == StFlush);
    packet_done  = (state_q == StDone);
    rx_pid       = rx_pid_q;
    rx_type      = rx_type_q;
    byte_count   = byte_count_q;
  end

endmodule

// File: tb/tb_rx_packet_cu.sv
// Scoreboard bench for rx_packet_cu: a packet-level model predicts output events.
module tb_rx_packet_cu;
  import rx_pkg::*;

  localparam int unsigned MaxBytes = 4;
  localparam int Limit = MaxBytes + 2;
  localparam int EvWrite = 0;
  localparam int EvFlush = 1;
  localparam int EvDone  = 2;
  localparam int EvErr   = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] data;
    logic [3:0] pid;
    logic [1:0] typ;
    logic [6:0] cnt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d_edge = 1'b0;
  logic       byte_received = 1'b0;
  logic       eop = 1'b0;
  logic [7:0] rcv_data = 8'h00;
  logic       rcving, r_error, w_enable, buffer_flush, packet_done;
  logic [3:0] rx_pid;
  logic [1:0] rx_type;
  logic [6:0] byte_count;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  mon_en = 1'b0;
  bit  err_prev = 1'b0;
  ev_t exp_q[$];

  logic [7:0] pkt[$];
  bit         coinc;
  logic [3:0] m_pid = 4'd0;
  logic [1:0] m_type = 2'd0;
  logic [6:0] m_cnt = 7'd0;
  bit         m_err = 1'b0;
  logic [3:0] pids[7] = '{PidOut, PidIn, PidSetup, PidData0, PidData1, PidAck, PidNak};

  rx_packet_cu #(
    .SYNC_BYTE      (SyncByteDefault),
    .MAX_DATA_BYTES (MaxBytes)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d_edge        (d_edge),
    .byte_received (byte_received),
    .rcv_data      (rcv_data),
    .eop           (eop),
    .rcving        (rcving),
    .r_error       (r_error),
    .w_enable      (w_enable),
    .buffer_flush  (buffer_flush),
    .packet_done   (packet_done),
    .rx_pid        (rx_pid),
    .rx_type       (rx_type),
    .byte_count    (byte_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ev_t mk(input int kind, input int c, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    e.pid  = m_pid;
    e.typ  = m_type;
    e.cnt  = m_cnt;
    return e;
  endfunction

  task automatic check_ev(input int kind);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL event: unexpected kind=%0d at cyc=%0d, none expected", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.cyc != cyc) begin
      bad++;
      $display("FAIL event: got kind=%0d cyc=%0d expected kind=%0d cyc=%0d",
               kind, cyc, e.kind, e.cyc);
    end else if (kind == EvWrite && rcv_data !== e.data) begin
      bad++;
      $display("FAIL write data: got %0h expected %0h", rcv_data, e.data);
    end else if (kind == EvDone && {rx_pid, rx_type, byte_count} !== {e.pid, e.typ, e.cnt}) begin
      bad++;
      $display("FAIL done fields: got pid=%0h type=%0d cnt=%0d expected pid=%0h type=%0d cnt=%0d",
               rx_pid, rx_type, byte_count, e.pid, e.typ, e.cnt);
    end
  endtask

  // Monitor: every strobe and every rising r_error consumes one predicted event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (w_enable === 1'b1)                     check_ev(EvWrite);
      if (buffer_flush === 1'b1)                 check_ev(EvFlush);
      if (packet_done === 1'b1)                  check_ev(EvDone);
      if (r_error === 1'b1 && !err_prev)         check_ev(EvErr);
    end
    err_prev <= (r_error === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(1, 3)) tick();
  endtask

  function automatic bit pid_ok(input logic [7:0] b);
    return (b[3:0] == ~b[7:4]) && (b[5:4] != 2'b00);
  endfunction

  // Predict the packet outcome from the byte list, then drive it and queue the events.
  task automatic run_packet();
    int         n = pkt.size();
    int         err_at = -1;
    int         wr_end = 0;
    bit         done = 1'b0;
    bit         is_data = 1'b0;
    logic [7:0] pb;
    if (n == 0 || pkt[0] != SyncByteDefault) begin
      err_at = 0;
    end else if (n == 1) begin
      err_at = 1;
    end else begin
      pb = pkt[1];
      if (!pid_ok(pb)) begin
        err_at = 1;
      end else begin
        m_pid  = pb[7:4];
        m_type = pb[5:4];
        if (pb[5:4] == 2'b01) begin
          if (n > 4) err_at = 4;
          else if (n == 4) done = 1'b1;
          else err_at = n;
        end else if (pb[5:4] == 2'b10) begin
          if (n > 2) err_at = 2;
          else done = 1'b1;
        end else begin
          is_data = 1'b1;
          if (n - 2 > Limit) err_at = 2 + Limit;
          else if (n - 2 >= 2) done = 1'b1;
          else err_at = n;
          wr_end = (err_at >= 0 && err_at < n) ? err_at : n;
          m_cnt  = 7'(wr_end - 2);
        end
      end
    end
    m_err = (err_at >= 0);

    tick();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    gap();
    for (int i = 0; i < n; i++) begin
      rcv_data      = pkt[i];
      byte_received = 1'b1;
      if (is_data && i == 1) exp_q.push_back(mk(EvFlush, cyc + 1, 8'h00));
      if (is_data && i >= 2 && i < wr_end) exp_q.push_back(mk(EvWrite, cyc + 1, pkt[i]));
      if (i == err_at) exp_q.push_back(mk(EvErr, cyc + 1, 8'h00));
      tick();
      byte_received = 1'b0;
      gap();
    end
    eop = 1'b1;
    if (coinc) begin
      byte_received = 1'b1;
      rcv_data      = 8'($urandom);
    end
    if (err_at == n) exp_q.push_back(mk(EvErr, cyc + 1, 8'h00));
    if (done) exp_q.push_back(mk(EvDone, cyc + 1, 8'h00));
    tick();
    eop           = 1'b0;
    byte_received = 1'b0;
    repeat (4) tick();

    check("rcving after eop", 32'(rcving), 0);
    check("r_error after eop", 32'(r_error), 32'(m_err));
    check("rx_pid", 32'(rx_pid), 32'(m_pid));
    check("rx_type", 32'(rx_type), 32'(m_type));
    check("byte_count", 32'(byte_count), 32'(m_cnt));
    check("events drained", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic gen_random();
    int         r = int'($urandom_range(0, 9));
    int         len;
    logic [7:0] b;
    logic [3:0] p;
    pkt.delete();
    if (r != 0) begin
      if (r == 1) begin
        b = 8'($urandom);
        if (b == SyncByteDefault) b = 8'h81;
        pkt.push_back(b);
      end else begin
        pkt.push_back(SyncByteDefault);
      end
      if ($urandom_range(0, 4) == 0) begin
        b = 8'($urandom);
      end else begin
        p = pids[$urandom_range(0, 6)];
        b = {p, ~p};
      end
      pkt.push_back(b);
      if (b[5:4] == 2'b01)      len = 2;
      else if (b[5:4] == 2'b10) len = 0;
      else                      len = int'($urandom_range(1, 6));
      if ($urandom_range(0, 3) == 0) len = int'($urandom_range(0, 8));
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    end
    coinc = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    repeat (3) tick();
    check("reset rcving", 32'(rcving), 0);
    check("reset r_error", 32'(r_error), 0);
    check("reset strobes", 32'({w_enable, buffer_flush, packet_done}), 0);
    check("reset rx_pid/type/count", 32'({rx_pid, rx_type, byte_count}), 0);
    rst    = 1'b0;
    tick();
    mon_en = 1'b1;

    coinc = 1'b0;
    pkt = '{8'h80, 8'h1E, 8'hA5, 8'h3C};                               run_packet();
    pkt = '{8'h80, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF};   run_packet();
    pkt = '{8'h80, 8'h2D};                                             run_packet();
    pkt = '{8'h80, 8'h2D, 8'h00};                                      run_packet();
    pkt = '{8'h80, 8'h1F};                                             run_packet();
    pkt = '{8'h80, 8'hD2, 8'h01, 8'h02};                               run_packet();
    pkt = '{8'h80, 8'h3C, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    run_packet();
    pkt = '{8'h80, 8'hB4, 8'h55};                                      run_packet();
    pkt = '{8'h81, 8'h1E};                                             run_packet();
    pkt.delete();                                                      run_packet();
    pkt = '{8'h80, 8'h0F};                                             run_packet();
    coinc = 1'b1;
    pkt = '{8'h80, 8'h4B, 8'h10, 8'h20};                               run_packet();

    for (int k = 0; k < 40; k++) begin
      gen_random();
      run_packet();
    end

    // Reset in the middle of a data packet, with eop and a byte arriving at the same edge.
    pkt = '{8'h80, 8'h3C, 8'h11, 8'h22, 8'h33};
    m_pid  = 4'h3;
    m_type = 2'b11;
    tick();
    d_edge = 1'b1;
    tick();
    d_edge = 1'b0;
    gap();
    for (int i = 0; i < 5; i++) begin
      rcv_data      = pkt[i];
      byte_received = 1'b1;
      if (i == 1) exp_q.push_back(mk(EvFlush, cyc + 1, 8'h00));
      if (i >= 2) exp_q.push_back(mk(EvWrite, cyc + 1, pkt[i]));
      tick();
      byte_received = 1'b0;
      gap();
    end
    rst           = 1'b1;
    eop           = 1'b1;
    byte_received = 1'b1;
    rcv_data      = 8'h99;
    tick();
    rst           = 1'b0;
    eop           = 1'b0;
    byte_received = 1'b0;
    m_pid  = 4'd0;
    m_type = 2'd0;
    m_cnt  = 7'd0;
    check("mid-packet reset status", 32'({rcving, r_error}), 0);
    check("mid-packet reset strobes", 32'({w_enable, buffer_flush, packet_done}), 0);
    check("mid-packet reset regs", 32'({rx_pid, rx_type, byte_count}), 0);
    repeat (4) tick();
    check("events after reset", 32'(exp_q.size()), 0);
    check("idle after reset", 32'({rcving, r_error}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
